// File: rtl/prim_word_packer.sv
// Packs Ratio consecutive InW-bit FIFO read words into one OutW-bit word with a per-lane valid mask.
// Define PRIM_WORD_PACKER_PARITY_EN to add parity_o (even parity per lane, registered with the word).
module prim_word_packer #(
  parameter int InW   = 16,
  parameter int Ratio = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [InW-1:0]       data_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [InW*Ratio-1:0] data_o,
  output logic [Ratio-1:0]     mask_o
`ifdef PRIM_WORD_PACKER_PARITY_EN
  ,
  output logic [Ratio-1:0]     parity_o
`endif
);

  localparam int OutW = InW * Ratio;
  localparam int CntW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [Ratio-1:0] MaskOne = Ratio'(1);

  logic                under_rst_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [InW-1:0]      acc_q [Ratio-1];
  logic [InW-1:0]      acc_d [Ratio-1];
  logic [OutW-1:0]     out_q, out_d;
  logic [Ratio-1:0]    mask_q, mask_d;
  logic                out_vld_q, out_vld_d;
  logic                flush_pend_q, flush_pend_d;
  logic                flush_done_q, flush_done_d;

  logic                drain, out_free, accept, cnt_last, cnt_zero;
  logic                load_full, load_part;
  logic [OutW-1:0]     full_word, part_word;
  logic [Ratio-1:0]    part_mask;

  // Both ports use strict valid/ready: a word moves on a cycle where valid and ready are both
  // high; a raised valid holds its data unchanged until that cycle.
  assign drain    = out_vld_q & ready_i;
  assign out_free = ~out_vld_q | drain;
  assign cnt_last = (cnt_q == LastCnt);
  assign cnt_zero = (cnt_q == '0);
  assign ready_o  = ~under_rst_q & ~flush_pend_q & ~(cnt_last & ~out_free);
  assign accept   = valid_i & ready_o;

  assign load_full = accept & cnt_last & ~clr_i;
  assign load_part = flush_pend_q & ~cnt_zero & out_free & ~clr_i;

  // Candidate output words: a complete word closed by the incoming lane, or a flushed partial.
  always_comb begin
    full_word = '0;
    part_word = '0;
    part_mask = '0;
    for (int k = 0; k < Ratio - 1; k++) begin
      full_word[k*InW +: InW] = acc_q[k];
      if (CntW'(k) < cnt_q) begin
        part_word[k*InW +: InW] = acc_q[k];
        part_mask[k]            = 1'b1;
      end
    end
    full_word[(Ratio-1)*InW +: InW] = data_i;
  end

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_d        = out_q;
    mask_d       = mask_q;
    out_vld_d    = out_vld_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    if (clr_i) begin
      cnt_d        = '0;
      out_vld_d    = 1'b0;
      flush_pend_d = 1'b0;
    end else begin
      if (drain) begin
        out_vld_d = 1'b0;
      end
      if (accept && !cnt_last) begin
        for (int k = 0; k < Ratio - 1; k++) begin
          if (cnt_q == CntW'(k)) begin
            acc_d[k] = data_i;
          end
        end
        cnt_d = cnt_q + CntOne;
      end
      if (load_full) begin
        out_d     = full_word;
        mask_d    = '1;
        out_vld_d = 1'b1;
        cnt_d     = '0;
      end
      if (flush_i && !flush_pend_q) begin
        flush_pend_d = 1'b1;
      end
      if (flush_pend_q && cnt_zero) begin
        flush_pend_d = 1'b0;
        flush_done_d = 1'b1;
      end
      if (load_part) begin
        out_d        = part_word;
        mask_d       = part_mask;
        out_vld_d    = 1'b1;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
        flush_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      under_rst_q  <= 1'b1;
      cnt_q        <= '0;
      out_q        <= '0;
      mask_q       <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      for (int k = 0; k < Ratio - 1; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      under_rst_q  <= 1'b0;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      mask_q       <= mask_d;
      out_vld_q    <= out_vld_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      for (int k = 0; k < Ratio - 1; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign valid_o      = out_vld_q;
  assign data_o       = out_q;
  assign mask_o       = mask_q;
  assign flush_done_o = flush_done_q;

`ifdef PRIM_WORD_PACKER_PARITY_EN
  logic [Ratio-1:0] par_q, par_d, full_par, part_par;

  always_comb begin
    for (int k = 0; k < Ratio; k++) begin
      full_par[k] = ^full_word[k*InW +: InW];
      part_par[k] = ^part_word[k*InW +: InW];
    end
  end

  always_comb begin
    par_d = par_q;
    if (load_full) begin
      par_d = full_par;
    end else if (load_part) begin
      par_d = part_par;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_o = par_q;
`endif

  a_out_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !clr_i) |=> (valid_o && $stable(data_o) && $stable(mask_o)));
  a_mask_contig: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o |-> (mask_o[0] && ((mask_o & (mask_o + MaskOne)) == '0)));
  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= LastCnt);
  a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_done_o |=> !flush_done_o);
  a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({valid_o, ready_o, flush_done_o, mask_o, data_o}));

endmodule

// File: tb/tb_prim_word_packer.sv
// Bench for prim_word_packer: reset, table of flush vectors, directed corner sequences,
// and a randomized run against a queue-based reference of the packing rules.
module tb_prim_word_packer;
  localparam int InW   = 16;
  localparam int Ratio = 4;
  localparam int OutW  = InW * Ratio;
  localparam int EW    = OutW + Ratio;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b1;
  logic              clr_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              ready_i = 1'b0;
  logic [InW-1:0]    data_i = '0;
  logic              ready_o, flush_done_o, valid_o;
  logic [OutW-1:0]   data_o;
  logic [Ratio-1:0]  mask_o;
`ifdef PRIM_WORD_PACKER_PARITY_EN
  logic [Ratio-1:0]  parity_o;
`endif

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  int exp_done = 0;
  logic [EW-1:0] mon_e;

  typedef struct {
    logic [OutW-1:0]  words;
    int               n;
    logic [OutW-1:0]  exp_data;
    logic [Ratio-1:0] exp_mask;
  } vec_t;

  prim_word_packer #(.InW(InW), .Ratio(Ratio)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .mask_o       (mask_o)
`ifdef PRIM_WORD_PACKER_PARITY_EN
    ,
    .parity_o     (parity_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [InW-1:0] w);
    valid_i = 1'b1;
    data_i  = w;
    #1;
    check1("feed_ready", ready_o, 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || exp_done != 0) && c < 50) begin
      tick();
      c++;
    end
    check_int(name, exp_q.size() + exp_done, 0);
  endtask

  // Scoreboard: every downstream handshake and every flush_done pulse must be expected.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL drain_unexpected: got %h want none", {mask_o, data_o});
        end else begin
          mon_e = exp_q.pop_front();
          checkw("drain_word", {mask_o, data_o}, mon_e);
        end
      end
      if (flush_done_o) begin
        total++;
        if (exp_done == 0) begin
          bad++;
          $display("FAIL flush_done_unexpected: got 1 want 0");
        end else begin
          exp_done--;
        end
      end
    end
  end

  initial begin
    vec_t             vecs[5];
    logic [InW-1:0]   w;
    logic [OutW-1:0]  word;
    logic [Ratio-1:0] m;
    logic [InW-1:0]   m_list[$];
    bit               m_pend;
    bit               got;
    bit               acc;
    logic             exp_rdy;
    int               c;

    vecs[0] = '{64'h4444_3333_2222_1111, 4, 64'h4444_3333_2222_1111, 4'hF};
    vecs[1] = '{64'hDEAD_BEEF_BBBB_AAAA, 2, 64'h0000_0000_BBBB_AAAA, 4'h3};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_0001, 1, 64'h0000_0000_0000_0001, 4'h1};
    vecs[3] = '{64'h7777_9ABC_5678_1234, 3, 64'h0000_9ABC_5678_1234, 4'h7};
    vecs[4] = '{64'h5555_5555_5555_5555, 0, 64'h0000_0000_0000_0000, 4'h0};

    // Reset and the one-cycle ready hold-off after release
    #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_valid", valid_o, 1'b0);
    checkw("rst_word", {mask_o, data_o}, '0);
    check1("rst_done", flush_done_o, 1'b0);
    check1("rst_ready", ready_o, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check1("under_rst_ready", ready_o, 1'b0);
    tick();
    check1("ready_after_rst", ready_o, 1'b1);

    // Streaming with downstream always ready
    ready_i = 1'b1;
    exp_q.push_back({4'hF, 64'h4444_3333_2222_1111});
    exp_q.push_back({4'hF, 64'h8888_7777_6666_5555});
    feed(16'h1111); feed(16'h2222); feed(16'h3333); feed(16'h4444);
    check1("stream_valid", valid_o, 1'b1);
    checkw("stream_word", {mask_o, data_o}, {4'hF, 64'h4444_3333_2222_1111});
    feed(16'h5555); feed(16'h6666); feed(16'h7777); feed(16'h8888);
    check1("stream_valid2", valid_o, 1'b1);
    checkw("stream_word2", {mask_o, data_o}, {4'hF, 64'h8888_7777_6666_5555});
    tick();
    check1("stream_idle", valid_o, 1'b0);

    // Backpressure: second group stalls on its last lane until the held word drains
    ready_i = 1'b0;
    for (int i = 0; i < 7; i++) feed(16'hA000 + 16'(i));
    valid_i = 1'b1;
    data_i  = 16'hA007;
    #1;
    check1("bp_ready_low", ready_o, 1'b0);
    tick();
    checkw("bp_hold", {mask_o, data_o}, {4'hF, 64'hA003_A002_A001_A000});
    ready_i = 1'b1;
    #1;
    check1("bp_ready_resume", ready_o, 1'b1);
    exp_q.push_back({4'hF, 64'hA003_A002_A001_A000});
    exp_q.push_back({4'hF, 64'hA007_A006_A005_A004});
    tick();
    valid_i = 1'b0;
    check1("bp_valid_kept", valid_o, 1'b1);
    checkw("bp_second", {mask_o, data_o}, {4'hF, 64'hA007_A006_A005_A004});
    tick();
    check1("bp_drained", valid_o, 1'b0);
    wait_empty("bp_empty");

    // Table: n words then flush, downstream stalled until the result is inspected
    for (int v = 0; v < 5; v++) begin
      ready_i = 1'b0;
      for (int k = 0; k < vecs[v].n; k++) begin
        w = vecs[v].words[k*InW +: InW];
        feed(w);
      end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      if (vecs[v].n > 0) exp_q.push_back({vecs[v].exp_mask, vecs[v].exp_data});
      exp_done++;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        if (flush_done_o) got = 1'b1;
        else tick();
      end
      check1("vec_done", got, 1'b1);
      check1("vec_valid", valid_o, vecs[v].n > 0);
      if (vecs[v].n > 0) checkw("vec_word", {mask_o, data_o}, {vecs[v].exp_mask, vecs[v].exp_data});
      ready_i = 1'b1;
      tick();
      check1("vec_done_once", flush_done_o, 1'b0);
      check1("vec_drained", valid_o, 1'b0);
    end
    wait_empty("vec_empty");

    // Flush with nothing buffered; a repeat flush while pending is ignored
    flush_i = 1'b1;
    exp_done++;
    tick();
    check1("f0_done_early", flush_done_o, 1'b0);
    tick();
    flush_i = 1'b0;
    check1("f0_done", flush_done_o, 1'b1);
    check1("f0_no_word", valid_o, 1'b0);
    tick();
    check1("f0_done_once", flush_done_o, 1'b0);
    tick();
    check1("f0_no_extra_done", flush_done_o, 1'b0);

    // Clear after word 6 drops words 5 and 6
    ready_i = 1'b1;
    exp_q.push_back({4'hF, 64'h0104_0103_0102_0101});
    for (int i = 1; i <= 6; i++) feed(16'h0100 + 16'(i));
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    exp_q.push_back({4'hF, 64'h010A_0109_0108_0107});
    exp_q.push_back({4'hF, 64'h010E_010D_010C_010B});
    for (int i = 7; i <= 16; i++) feed(16'h0100 + 16'(i));
    exp_q.push_back({4'h3, 64'h0000_0000_0110_010F});
    exp_done++;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_empty("clr_empty");

    // Reset in the middle of packing
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) feed(16'hB000 + 16'(i));
    check1("mid_valid_before", valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check1("mid_rst_valid", valid_o, 1'b0);
    check1("mid_rst_mask", mask_o == '0, 1'b1);
    check1("mid_rst_ready", ready_o, 1'b0);
    exp_q.delete();
    exp_done = 0;
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check1("mid_under_rst", ready_o, 1'b0);
    tick();
    check1("mid_ready_back", ready_o, 1'b1);
    feed(16'h0001); feed(16'h0003); feed(16'h0007); feed(16'h8000);
    checkw("mid_lane0", {mask_o, data_o}, {4'hF, 64'h8000_0007_0003_0001});
`ifdef PRIM_WORD_PACKER_PARITY_EN
    check_int("parity", int'(parity_o), 32'hD);
`endif
    exp_q.push_back({4'hF, 64'h8000_0007_0003_0001});
    ready_i = 1'b1;
    tick();
    wait_empty("mid_empty");

    // Randomized run: accepted words are grouped by the model, flushes emit what is left
    m_pend = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (flush_done_o) m_pend = 1'b0;
      valid_i = ($urandom_range(0, 3) != 0);
      data_i  = 16'($urandom);
      ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      #1;
      exp_rdy = !m_pend && !(m_list.size() == Ratio - 1 && valid_o && !ready_i);
      check1("rand_ready", ready_o, exp_rdy);
      acc = valid_i && ready_o;
      if (acc) begin
        m_list.push_back(data_i);
        if (m_list.size() == Ratio) begin
          word = '0;
          for (int k = 0; k < Ratio; k++) word[k*InW +: InW] = m_list[k];
          exp_q.push_back({{Ratio{1'b1}}, word});
          m_list.delete();
        end
      end
      if (flush_i && !m_pend) begin
        m_pend = 1'b1;
        exp_done++;
        if (m_list.size() > 0) begin
          word = '0;
          for (int k = 0; k < m_list.size(); k++) word[k*InW +: InW] = m_list[k];
          m = Ratio'((1 << m_list.size()) - 1);
          exp_q.push_back({m, word});
          m_list.delete();
        end
      end
      tick();
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    if (flush_done_o) m_pend = 1'b0;
    c = 0;
    while (m_pend && c < 50) begin
      tick();
      if (flush_done_o) m_pend = 1'b0;
      c++;
    end
    check1("rand_pend_clear", m_pend, 1'b0);
    exp_done++;
    if (m_list.size() > 0) begin
      word = '0;
      for (int k = 0; k < m_list.size(); k++) word[k*InW +: InW] = m_list[k];
      m = Ratio'((1 << m_list.size()) - 1);
      exp_q.push_back({m, word});
      m_list.delete();
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_empty("rand_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
